// File: rtl/hbridge_pwm_pkg.sv
// Shared definitions for the H-bridge PWM block: direction codes (also used by the
// direction detector) and the 3-bit FSM state encoding reported on the telemetry bus.
package hbridge_pwm_pkg;

  localparam logic [1:0] CTRL_COAST = 2'b00;
  localparam logic [1:0] CTRL_FWD   = 2'b01;
  localparam logic [1:0] CTRL_REV   = 2'b10;
  localparam logic [1:0] CTRL_BRAKE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FWD   = 3'd1,
    ST_REV   = 3'd2,
    ST_BRAKE = 3'd3,
    ST_DEAD  = 3'd4
  } state_e;

  // True in the two states where the PWM counter runs and a pin toggles.
  function automatic logic is_drive(state_e s);
    return (s == ST_FWD) || (s == ST_REV);
  endfunction

endpackage

// File: rtl/hbridge_pwm_if.sv
// Command/pin bundle between the wheel controller side (master) and the H-bridge
// PWM block (slave).
interface hbridge_pwm_if
  import hbridge_pwm_pkg::*;
#(
  parameter int N_DATAWIDTH = 17
);

  logic [1:0]             HBRIDGE_PWM_CONTROL_InBus;
  logic [N_DATAWIDTH-1:0] HBRIDGE_PWM_W_InBus;
  logic                   HBRIDGE_PWM_IN1_Out;
  logic                   HBRIDGE_PWM_IN2_Out;
  state_e                 HBRIDGE_PWM_STATE_OutBus;
  logic                   HBRIDGE_PWM_PERIOD_Out;

  modport master (
    output HBRIDGE_PWM_CONTROL_InBus,
    output HBRIDGE_PWM_W_InBus,
    input  HBRIDGE_PWM_IN1_Out,
    input  HBRIDGE_PWM_IN2_Out,
    input  HBRIDGE_PWM_STATE_OutBus,
    input  HBRIDGE_PWM_PERIOD_Out
  );

  modport slave (
    input  HBRIDGE_PWM_CONTROL_InBus,
    input  HBRIDGE_PWM_W_InBus,
    output HBRIDGE_PWM_IN1_Out,
    output HBRIDGE_PWM_IN2_Out,
    output HBRIDGE_PWM_STATE_OutBus,
    output HBRIDGE_PWM_PERIOD_Out
  );

endinterface

// File: rtl/hbridge_pwm_counter.sv
// PWM period counter: counts 0..PERIOD-1 and wraps while enabled; a synchronous
// clear holds it at zero. Flags the terminal count and the zero count.
module hbridge_pwm_counter #(
  parameter int WIDTH  = 12,
  parameter int PERIOD = 2500
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             zero
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(PERIOD - 1);

  // NOTE: registers are written with non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

  assign tc   = (count == LAST);
  assign zero = (count == '0);

endmodule

// File: rtl/hbridge_pwm.sv
// H-bridge PWM driver: direction FSM with dead interval on reversal, duty latched at
// period boundaries, and registered IN1/IN2/PERIOD outputs.
module hbridge_pwm
  import hbridge_pwm_pkg::*;
#(
  parameter int N_DATAWIDTH = 17,
  parameter int PWM_PERIOD  = 2500,
  parameter int DEADTIME    = 50
) (
  input  logic         HBRIDGE_PWM_CLOCK_50,
  input  logic         HBRIDGE_PWM_RESET_InLow,
  hbridge_pwm_if.slave bus
);

  // Duty must be able to hold PWM_PERIOD itself (100 % duty).
  localparam int CW = $clog2(PWM_PERIOD + 1);
  localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

  localparam logic [N_DATAWIDTH-1:0] PERIOD_W  = N_DATAWIDTH'(PWM_PERIOD);
  localparam logic [CW-1:0]          PERIOD_C  = CW'(PWM_PERIOD);
  localparam logic [DW-1:0]          DEAD_LOAD = DW'(DEADTIME - 1);

  logic clk;
  logic rst_n;
  assign clk   = HBRIDGE_PWM_CLOCK_50;
  assign rst_n = HBRIDGE_PWM_RESET_InLow;

  logic [1:0]             code;
  logic [N_DATAWIDTH-2:0] mag;
  logic                   unused_sign;
  assign code        = bus.HBRIDGE_PWM_CONTROL_InBus;
  assign mag         = bus.HBRIDGE_PWM_W_InBus[N_DATAWIDTH-2:0];
  assign unused_sign = bus.HBRIDGE_PWM_W_InBus[N_DATAWIDTH-1];

  // Magnitudes of a full period or more saturate to constant-high drive.
  logic [CW-1:0] duty_next;
  assign duty_next = ({1'b0, mag} >= PERIOD_W) ? PERIOD_C : CW'(mag);

  state_e        state;
  logic [DW-1:0] dead_cnt;
  logic [CW-1:0] duty_q;
  logic          in1_q;
  logic          in2_q;
  logic          period_q;

  logic [CW-1:0] count;
  logic          tc;
  logic          zero;

  logic   stop_req;
  logic   reverse_req;
  logic   pwm;
  state_e dir_state;
  logic   cnt_clr;
  logic   cnt_en;

  assign stop_req  = (code == CTRL_COAST) || (code == CTRL_BRAKE);
  assign dir_state = (code == CTRL_FWD) ? ST_FWD : ST_REV;

  // A reversal request is only honoured on the last clock of a period so the
  // running pulse is never truncated.
  assign reverse_req = tc &&
                       (((state == ST_FWD) && (code == CTRL_REV)) ||
                        ((state == ST_REV) && (code == CTRL_FWD)));

  assign pwm = (count < duty_q);

  // The counter is cleared in the same edge that leaves FWD/REV, so it already
  // reads 0 on the first non-driving cycle.
  assign cnt_en  = is_drive(state);
  assign cnt_clr = !is_drive(state) || stop_req || reverse_req;

  hbridge_pwm_counter #(
    .WIDTH  (CW),
    .PERIOD (PWM_PERIOD)
  ) u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (count),
    .tc    (tc),
    .zero  (zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      dead_cnt <= '0;
      duty_q   <= '0;
      in1_q    <= 1'b0;
      in2_q    <= 1'b0;
      period_q <= 1'b0;
    end else begin
      // Pins follow the state/counter of the current cycle, one clock later.
      in1_q    <= ((state == ST_FWD) && pwm) || (state == ST_BRAKE);
      in2_q    <= ((state == ST_REV) && pwm) || (state == ST_BRAKE);
      period_q <= is_drive(state) && zero;

      if (code == CTRL_BRAKE) begin
        state <= ST_BRAKE;
      end else if (code == CTRL_COAST) begin
        state <= ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE, ST_BRAKE: begin
            state  <= dir_state;
            duty_q <= duty_next;
          end
          ST_FWD, ST_REV: begin
            if (tc) begin
              duty_q <= duty_next;
            end
            if (reverse_req) begin
              state    <= ST_DEAD;
              dead_cnt <= DEAD_LOAD;
            end
          end
          ST_DEAD: begin
            if (dead_cnt == '0) begin
              state  <= dir_state;
              duty_q <= duty_next;
            end else begin
              dead_cnt <= dead_cnt - 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.HBRIDGE_PWM_IN1_Out      = in1_q;
  assign bus.HBRIDGE_PWM_IN2_Out      = in2_q;
  assign bus.HBRIDGE_PWM_PERIOD_Out   = period_q;
  assign bus.HBRIDGE_PWM_STATE_OutBus = state;

endmodule

// File: tb/tb_hbridge_pwm.sv
// Self-checking bench for hbridge_pwm: directed scenarios with literal expectations
// plus randomized commands compared every cycle against an absolute-time model.
module tb_hbridge_pwm;
  import hbridge_pwm_pkg::*;

  localparam int          NW     = 17;
  localparam int unsigned PERIOD = 2500;
  localparam int unsigned DEAD   = 50;

  logic clk;
  logic rst_n;

  hbridge_pwm_if #(.N_DATAWIDTH(NW)) bus ();

  hbridge_pwm #(
    .N_DATAWIDTH (NW),
    .PWM_PERIOD  (PERIOD),
    .DEADTIME    (DEAD)
  ) dut (
    .HBRIDGE_PWM_CLOCK_50    (clk),
    .HBRIDGE_PWM_RESET_InLow (rst_n),
    .bus                     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (absolute cycle time) ----------------
  state_e      m_state;
  int unsigned now_cyc;
  int unsigned t0;        // cycle on which the current drive period started at count 0
  int unsigned dead_end;  // last cycle spent in the dead interval
  int          duty;
  logic        e_in1, e_in2, e_per;

  function automatic int clamp_duty(input logic [NW-1:0] w);
    int mag;
    mag = int'(w[NW-2:0]);
    return (mag > int'(PERIOD)) ? int'(PERIOD) : mag;
  endfunction

  function automatic int m_count();
    if (m_state == ST_FWD || m_state == ST_REV) return int'((now_cyc - t0) % PERIOD);
    return 0;
  endfunction

  task automatic model_reset();
    m_state = ST_IDLE;
    duty    = 0;
    e_in1   = 1'b0;
    e_in2   = 1'b0;
    e_per   = 1'b0;
  endtask

  task automatic model_step();
    int     cnt;
    logic   [1:0] c;
    state_e want;
    cnt  = m_count();
    c    = bus.HBRIDGE_PWM_CONTROL_InBus;
    want = (c == CTRL_FWD) ? ST_FWD : ST_REV;
    e_in1 = (m_state == ST_FWD && cnt < duty) || m_state == ST_BRAKE;
    e_in2 = (m_state == ST_REV && cnt < duty) || m_state == ST_BRAKE;
    e_per = (m_state == ST_FWD || m_state == ST_REV) && cnt == 0;
    if (c == CTRL_BRAKE) m_state = ST_BRAKE;
    else if (c == CTRL_COAST) m_state = ST_IDLE;
    else begin
      case (m_state)
        ST_IDLE, ST_BRAKE: begin
          m_state = want; duty = clamp_duty(bus.HBRIDGE_PWM_W_InBus); t0 = now_cyc + 1;
        end
        ST_FWD, ST_REV: begin
          if (cnt == int'(PERIOD) - 1) begin
            duty = clamp_duty(bus.HBRIDGE_PWM_W_InBus);
            if (want != m_state) begin
              m_state  = ST_DEAD;
              dead_end = now_cyc + DEAD;
            end
          end
        end
        ST_DEAD: begin
          if (now_cyc == dead_end) begin
            m_state = want; duty = clamp_duty(bus.HBRIDGE_PWM_W_InBus); t0 = now_cyc + 1;
          end
        end
        default: ;
      endcase
    end
    now_cyc++;
  endtask

  initial begin
    now_cyc = 0;
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial forever begin
    @(negedge rst_n);
    model_reset();
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    check("in1", bus.HBRIDGE_PWM_IN1_Out, e_in1);
    check("in2", bus.HBRIDGE_PWM_IN2_Out, e_in2);
    check("period", bus.HBRIDGE_PWM_PERIOD_Out, e_per);
    check("state", bus.HBRIDGE_PWM_STATE_OutBus, m_state);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_cmd(input logic [1:0] c, input logic [NW-1:0] w);
    bus.HBRIDGE_PWM_CONTROL_InBus = c;
    bus.HBRIDGE_PWM_W_InBus       = w;
  endtask

  task automatic step_to_edge(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic window(input int n, output int h1, output int h2, output int pp);
    h1 = 0; h2 = 0; pp = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      h1 += int'(bus.HBRIDGE_PWM_IN1_Out);
      h2 += int'(bus.HBRIDGE_PWM_IN2_Out);
      pp += int'(bus.HBRIDGE_PWM_PERIOD_Out);
    end
  endtask

  task automatic wait_state(input state_e s, input int limit, output int waited, output bit found);
    found = 0; waited = limit;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (bus.HBRIDGE_PWM_STATE_OutBus == s) begin
        found = 1; waited = k; break;
      end
    end
  endtask

  initial begin
    int h1, h2, pp, waited, dead_n, first_in2, viol;
    bit found;
    logic [1:0] rc;
    logic [NW-1:0] rw;
    int hold;

    set_cmd(CTRL_COAST, '0);
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    @(negedge clk);
    check("rst_in1", bus.HBRIDGE_PWM_IN1_Out, 0);
    check("rst_in2", bus.HBRIDGE_PWM_IN2_Out, 0);
    check("rst_period", bus.HBRIDGE_PWM_PERIOD_Out, 0);
    check("rst_state", bus.HBRIDGE_PWM_STATE_OutBus, ST_IDLE);
    step_to_edge(2);
    rst_n = 1'b1;
    step_to_edge(3);

    // Forward at 25 % duty.
    set_cmd(CTRL_FWD, 17'd625);
    repeat (2) @(posedge clk);
    window(PERIOD, h1, h2, pp);
    check("fwd625_in1_high", h1, 625);
    check("fwd625_in2_high", h2, 0);
    check("fwd625_pulses", pp, 1);

    // Reverse with an oversize magnitude saturates to constant high.
    step_to_edge(1); set_cmd(CTRL_COAST, '0); step_to_edge(3);
    set_cmd(CTRL_REV, 17'h0FFFF);
    repeat (2) @(posedge clk);
    window(PERIOD, h1, h2, pp);
    check("revmax_in2_high", h2, 2500);
    check("revmax_in1_high", h1, 0);

    // Zero magnitude forward: no drive, but the period still runs.
    step_to_edge(1); set_cmd(CTRL_COAST, '0); step_to_edge(3);
    set_cmd(CTRL_FWD, '0);
    repeat (2) @(posedge clk);
    window(PERIOD, h1, h2, pp);
    check("fwd0_pins_high", h1 + h2, 0);
    check("fwd0_pulses", pp, 1);

    // Reversal requested at count 300.
    step_to_edge(1); set_cmd(CTRL_COAST, '0); step_to_edge(3);
    set_cmd(CTRL_FWD, 17'd1000);
    step_to_edge(301);
    set_cmd(CTRL_REV, 17'd1000);
    wait_state(ST_DEAD, 3000, waited, found);
    check("rev_dead_found", found, 1);
    check("rev_fwd_hold", waited, 2200);
    dead_n = 1; first_in2 = -1; viol = 0; h2 = 0;
    for (int k = 1; k <= 2550; k++) begin
      @(negedge clk);
      if (bus.HBRIDGE_PWM_STATE_OutBus == ST_DEAD) dead_n++;
      if (k <= 50 && (bus.HBRIDGE_PWM_IN1_Out || bus.HBRIDGE_PWM_IN2_Out)) viol++;
      if (first_in2 < 0 && bus.HBRIDGE_PWM_IN2_Out) first_in2 = k;
      if (k >= 51) h2 += int'(bus.HBRIDGE_PWM_IN2_Out);
    end
    check("rev_dead_len", dead_n, 50);
    check("rev_dead_pins", viol, 0);
    check("rev_first_in2", first_in2, 51);
    check("rev_in2_high", h2, 1000);

    // Brake at count 800, then resume forward without a dead interval.
    step_to_edge(1); set_cmd(CTRL_COAST, '0); step_to_edge(5);
    set_cmd(CTRL_FWD, 17'd1000);
    step_to_edge(801);
    set_cmd(CTRL_BRAKE, 17'd1000);
    @(posedge clk); @(negedge clk);
    check("brake_1clk_in2", bus.HBRIDGE_PWM_IN2_Out, 0);
    check("brake_1clk_state", bus.HBRIDGE_PWM_STATE_OutBus, ST_BRAKE);
    @(posedge clk); @(negedge clk);
    check("brake_2clk_pins", {bus.HBRIDGE_PWM_IN1_Out, bus.HBRIDGE_PWM_IN2_Out}, 2'b11);
    step_to_edge(10);
    set_cmd(CTRL_FWD, 17'd1000);
    @(posedge clk); @(negedge clk);
    check("resume_state", bus.HBRIDGE_PWM_STATE_OutBus, ST_FWD);
    @(posedge clk); @(negedge clk);
    check("resume_pulse", bus.HBRIDGE_PWM_PERIOD_Out, 1);
    check("resume_in1", bus.HBRIDGE_PWM_IN1_Out, 1);

    // Coast during the dead interval aborts it for good.
    step_to_edge(1);
    set_cmd(CTRL_REV, 17'd1000);
    wait_state(ST_DEAD, 3000, waited, found);
    check("abort_dead_found", found, 1);
    step_to_edge(1);
    set_cmd(CTRL_COAST, 17'd1000);
    @(posedge clk);
    viol = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.HBRIDGE_PWM_STATE_OutBus != ST_IDLE || bus.HBRIDGE_PWM_IN1_Out ||
          bus.HBRIDGE_PWM_IN2_Out) viol++;
    end
    check("abort_dead_idle", viol, 0);

    // Asynchronous reset at count 1200 in reverse.
    step_to_edge(1);
    set_cmd(CTRL_REV, 17'd1500);
    step_to_edge(1201);
    check("prerst_in2", bus.HBRIDGE_PWM_IN2_Out, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_pins", {bus.HBRIDGE_PWM_IN1_Out, bus.HBRIDGE_PWM_IN2_Out}, 2'b00);
    check("async_rst_state", bus.HBRIDGE_PWM_STATE_OutBus, ST_IDLE);
    set_cmd(CTRL_COAST, '0);
    step_to_edge(3);
    rst_n = 1'b1;
    viol = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.HBRIDGE_PWM_STATE_OutBus != ST_IDLE) viol++;
    end
    check("post_rst_idle", viol, 0);
    step_to_edge(1);
    set_cmd(CTRL_FWD, 17'd100);
    @(posedge clk); @(negedge clk);
    check("post_rst_fwd", bus.HBRIDGE_PWM_STATE_OutBus, ST_FWD);

    // Randomized commands; the every-cycle compare does the checking.
    step_to_edge(1);
    for (int seg = 0; seg < 60; seg++) begin
      case ($urandom_range(0, 9))
        0:       rc = CTRL_COAST;
        1:       rc = CTRL_BRAKE;
        2, 3, 4, 5: rc = CTRL_FWD;
        default: rc = CTRL_REV;
      endcase
      case ($urandom_range(0, 5))
        0:       rw = '0;
        1:       rw = NW'(PERIOD - 1);
        2:       rw = NW'(PERIOD);
        3:       rw = NW'(PERIOD + 1);
        4:       rw = NW'($urandom_range(0, 131071));
        default: rw = NW'($urandom_range(0, PERIOD));
      endcase
      set_cmd(rc, rw);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 60) : $urandom_range(200, 1200);
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        step_to_edge(2);
        rst_n = 1'b1;
      end
      step_to_edge(hold);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
